interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter N_SRC, default 8, meaning number of interrupt source lines (fixed at 8 for this revision).
REQ-002 Parameter VEC_BASE, default 8'h20, meaning vector number of source 0; source i yields VEC_BASE+i.
REQ-003 clk_i  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 irq_src_i  input  8  peripheral interrupt lines (same clock domain), rising-edge triggered.
REQ-006 irq_o  output  1  interrupt request to CPU, registered.
REQ-007 inta_i  input  1  CPU interrupt acknowledge, single-cycle pulse.
REQ-008 vector_o  output  8  acknowledged vector, held until next acknowledge.
REQ-009 vec_valid_o  output  1  one-cycle strobe, vector_o valid.
REQ-010 addr_i  input  2  register select: 0 MASK, 1 PEND, 2 INSV, 3 EOI.
REQ-011 wdata_i  input  8  register write data.
REQ-012 we_i  input  1  register write strobe, one write per cycle.
REQ-013 rdata_o  output  8  register read data, combinational from addr_i.

Function
REQ-014 Edge detect: registered copy src_q of irq_src_i; bit i of PEND set on the edge after sampling src_q[i]=0 and irq_src_i[i]=1.
REQ-015 MASK: read/write; bit=1 masks source; masking does not clear PEND.
REQ-016 PEND: read; write-1-to-clear; a new edge on the same bit in the same cycle as its clear leaves the bit set.
REQ-017 INSV: read-only; at most one bit set (no nesting).
REQ-018 EOI: write of any value with FSM in BUSY clears INSV, FSM -> IDLE; EOI write in other states ignored; read of addr 3 returns last vector_o.
REQ-019 Priority: lowest index wins among PEND & ~MASK.
REQ-020 FSM states IDLE, REQ, BUSY; irq_o = (state==REQ), registered.
REQ-021 IDLE -> REQ when (PEND & ~MASK) != 0; irq_o high two cycles after the edge that samples the source rising.
REQ-022 REQ with inta_i=1: winner index w chosen from current PEND & ~MASK; PEND[w] cleared, INSV[w] set, vector_o = VEC_BASE+w, vec_valid_o=1 on next cycle only; FSM -> BUSY.
REQ-023 REQ with (PEND & ~MASK)==0 and inta_i=0 (cleared or masked before ack): FSM -> IDLE, irq_o drops next cycle.
REQ-024 REQ with (PEND & ~MASK)==0 and inta_i=1 same cycle: spurious vector VEC_BASE+8, vec_valid_o pulse, FSM -> IDLE, INSV unchanged.
REQ-025 inta_i in IDLE or BUSY: spurious vector VEC_BASE+8 with vec_valid_o pulse; no state change.
REQ-026 Sources arriving in BUSY are latched into PEND and served after EOI in priority order.
REQ-027 Vector arithmetic 8-bit, wraps modulo 256.

Reset
REQ-028 rst_i=1 asynchronously forces: state IDLE, MASK=8'hFF, PEND=0, INSV=0, src_q=0, irq_o=0, vector_o=0, vec_valid_o=0.
REQ-029 Reset mid-handshake (REQ or BUSY) abandons the request; no vec_valid_o pulse after release.
REQ-030 Source held high through reset release does not set PEND (src_q reloads from input first cycle); rising edge required.

Verification
REQ-031 MASK=8'hFE, pulse irq_src_i[0] -> irq_o high 2 cycles later; inta_i -> vector_o=8'h20, vec_valid_o 1 cycle, INSV=8'h01, PEND=0.
REQ-032 MASK=0, irq_src_i[5] and [2] rise same cycle; ack -> 8'h22; EOI; ack -> 8'h25; EOI -> PEND=INSV=0, irq_o=0.
REQ-033 Source 3 pending, irq_o high; write MASK=8'h08 before ack -> irq_o low next cycle, PEND=8'h08 retained; unmask -> irq_o reasserts.
REQ-034 inta_i with PEND=0 in IDLE -> vector_o=8'h28, vec_valid_o pulse, state IDLE, INSV=0.
REQ-035 Write PEND=8'h10 in the same cycle a new edge on source 4 is registered -> PEND[4] stays 1.
REQ-036 Assert rst_i asynchronously while in BUSY -> all outputs/registers at reset values immediately; MASK reads 8'hFF.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: peripheral IRQ lines, CPU acknowledge/vector and register port.
// Clock and reset stay outside as plain ports of the controller.
interface interrupt_controller_if;
  logic [7:0] irq_src_i;
  logic       irq_o;
  logic       inta_i;
  logic [7:0] vector_o;
  logic       vec_valid_o;
  logic [1:0] addr_i;
  logic [7:0] wdata_i;
  logic       we_i;
  logic [7:0] rdata_o;

  modport master (
    output irq_src_i, inta_i, addr_i, wdata_i, we_i,
    input  irq_o, vector_o, vec_valid_o, rdata_o
  );

  modport slave (
    input  irq_src_i, inta_i, addr_i, wdata_i, we_i,
    output irq_o, vector_o, vec_valid_o, rdata_o
  );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-triggered 8-source interrupt controller, fixed lowest-index priority, single in-service level.
// irq_o rises two cycles after a source rises; vec_valid_o strobes the cycle after an acknowledge.
module interrupt_controller #(
  parameter int         N_SRC    = 8,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input logic                   clk_i,
  input logic                   rst_i,
  interrupt_controller_if.slave bus
);

  localparam logic [7:0] SPUR_VEC = VEC_BASE + 8'(N_SRC);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t     state, state_nxt;
  logic [7:0] src_q;
  logic       armed;
  logic [7:0] mask;
  logic [7:0] pend;
  logic [7:0] insv;
  logic [7:0] vector_q;
  logic       vec_valid_q;

  logic [7:0] rise;
  logic [7:0] active;
  logic [7:0] pend_wclr;
  logic [7:0] win_onehot;
  logic [2:0] win_idx;
  logic       eoi_wr;
  logic       ack_win;
  logic       ack_spur;
  logic       eoi_take;

  // armed blocks edge detection on the first cycle after reset so that a
  // source held high through reset release is not mistaken for a new edge
  assign rise      = armed ? (bus.irq_src_i & ~src_q) : '0;
  assign active    = pend & ~mask;
  assign pend_wclr = (bus.we_i && bus.addr_i == 2'd1) ? bus.wdata_i : '0;
  assign eoi_wr    = bus.we_i && (bus.addr_i == 2'd3);

  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_idx = 3'(i);
    end
    win_onehot = 8'b1 << win_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_win   = 1'b0;
    ack_spur  = 1'b0;
    eoi_take  = 1'b0;
    case (state)
      IDLE: begin
        ack_spur = bus.inta_i;
        if (active != '0) state_nxt = REQ;
      end
      REQ: begin
        if (bus.inta_i) begin
          if (active != '0) begin
            ack_win   = 1'b1;
            state_nxt = BUSY;
          end else begin
            ack_spur  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (active == '0) begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        ack_spur = bus.inta_i;
        if (eoi_wr) begin
          eoi_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q       <= '0;
      armed       <= 1'b0;
      mask        <= 8'hFF;
      pend        <= '0;
      insv        <= '0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      src_q       <= bus.irq_src_i;
      armed       <= 1'b1;
      vec_valid_q <= ack_win | ack_spur;
      if (bus.we_i && bus.addr_i == 2'd0) mask <= bus.wdata_i;
      // a fresh edge wins over a same-cycle software clear
      pend <= (pend & ~pend_wclr & ~(ack_win ? win_onehot : 8'h00)) | rise;
      if (ack_win)       insv <= win_onehot;
      else if (eoi_take) insv <= '0;
      if (ack_win)       vector_q <= VEC_BASE + {5'b0, win_idx};
      else if (ack_spur) vector_q <= SPUR_VEC;
    end
  end

  always_comb begin
    case (bus.addr_i)
      2'd0:    bus.rdata_o = mask;
      2'd1:    bus.rdata_o = pend;
      2'd2:    bus.rdata_o = insv;
      default: bus.rdata_o = vector_q;
    endcase
  end

  assign bus.irq_o       = (state == REQ);
  assign bus.vector_o    = vector_q;
  assign bus.vec_valid_o = vec_valid_q;

endmodule
